clkdiv_ratio_ctrl: RTL and testbench
====================================

// Module: clkdiv_ratio_ctrl
// PURPOSE
//  Upstream control stage for the programmable clock divider. Accepts ratio writes from the
//  config side in the clkin domain and range-checks them. Drives the divider's ratio bus and
//  runs the four-phase ratio_upd_req/ratio_upd_ack handshake. ratio is held stable whenever
//  req is high. Supports one pending write and an ack timeout, and reports done/error status.
// PARAMETERS
//  RATIO_W      10    width of ratio bus
//  RATIO_MIN    2     smallest legal ratio (inclusive)
//  RATIO_MAX    1023  largest legal ratio (inclusive)
//  RESET_RATIO  10    ratio driven out of reset
//  HOLD_CYC     2     clkin cycles req stays high after ack_s rises
//  ACK_TIMEOUT  255   clkin cycles allowed per handshake phase before abort
// PORTS
//  clkin          in   1        single clock, also the divider input clock
//  rstb           in   1        reset, asynchronous, active-low
//  cfg_wr         in   1        1-cycle write strobe
//  cfg_ratio      in   RATIO_W  requested ratio, sampled when cfg_wr=1
//  cfg_busy       out  1        handshake in progress or pending write held
//  cfg_done       out  1        1-cycle pulse: a ratio was committed (or was a no-op)
//  cfg_err        out  1        1-cycle pulse: write rejected or handshake aborted
//  err_code       out  2        00 none, 01 RANGE, 10 TIMEOUT; held until next cfg_wr
//  cur_ratio      out  RATIO_W  last ratio acknowledged by the divider
//  ratio          out  RATIO_W  to divider; changes only while in IDLE
//  ratio_upd_req  out  1        to divider
//  ratio_upd_ack  in   1        from divider (clkout domain, asynchronous to clkin)
// BEHAVIOUR
//  - Reset: ratio=cur_ratio=RESET_RATIO, ratio_upd_req=0, cfg_busy=cfg_done=cfg_err=0,
//    err_code=00, pending empty, state IDLE. Asserting rstb mid-handshake drops req
//    immediately.
//  - ratio_upd_ack passes through a 2-FF synchronizer, giving ack_s. All decisions use ack_s.
//  - Write check: cfg_ratio<RATIO_MIN or >RATIO_MAX -> discarded, cfg_err pulse next cycle,
//    err_code=01, no state change.
//  - Write equal to cur_ratio while IDLE -> cfg_done pulse next cycle, no handshake.
//  - FSM:
//    - IDLE: legal write (or pending valid) -> load ratio, ->REQ. req rises one cycle after cfg_wr.
//    - REQ: req=1. ack_s=1 -> HOLD, clear timer. Timer reaches ACK_TIMEOUT -> ABORT.
//    - HOLD: req=1 for HOLD_CYC cycles -> DROP.
//    - DROP: req=0. ack_s=0 -> cur_ratio<=ratio, cfg_done pulse, ->IDLE. Timer reaches
//      ACK_TIMEOUT -> ABORT.
//    - ABORT: req=0, ratio<=cur_ratio, cfg_err pulse, err_code=10, pending cleared, ->IDLE.
//  - Timer: clog2(ACK_TIMEOUT+1) bits. Cleared on each state entry; saturates; runs only in
//    REQ/DROP.
//  - Pending: a legal write while not IDLE is stored in a 1-entry register. A later write
//    overwrites it (last wins). It launches in the cycle after returning to IDLE.
//  - A write arriving in the same cycle as DROP completion goes to pending. It is not
//    compared with the old cur_ratio.
//  - cfg_busy = (state!=IDLE) | pending_v.
//  - Invariant: ratio never changes while req=1 or ack_s=1.
// STRUCTURE
//  - clkdiv_pkg: RATIO_W default, state_e {IDLE,REQ,HOLD,DROP,ABORT}, err_e {NONE,RANGE,TIMEOUT}.
//  - Sub-module sync_2ff (1-bit, async-reset-to-0) for ratio_upd_ack. Everything else is in
//    one FSM block.
// TESTING (bench drives clkdiv10 with this block in place of TB handshake)
//  1. Reset release, no writes -> ratio=10, req=0, busy=0 for 50 cycles.
//  2. cfg_wr ratio=25 -> req rises next cycle, held 2 cycles after ack_s, done pulse once,
//     cur_ratio=25.
//  3. cfg_wr ratio=1 then 1024 -> two cfg_err pulses, err_code=01, ratio unchanged, no req.
//  4. Writes 30,31,32 during one handshake -> committed sequence 30 then 32, two done pulses.
//  5. ack tied 0, write 20 -> after 255 cycles in REQ: err pulse, err_code=10, ratio back
//     to cur_ratio.
//  6. rstb low mid-HOLD -> req drops async, all outputs at reset values.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types for the clock-divider ratio control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clkdiv_pkg;

  // Default ratio bus width for the divider and its control stage.
  localparam int RATIO_W_DFLT = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DROP  = 3'd3,
    ABORT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    RANGE   = 2'b01,
    TIMEOUT = 2'b10
  } err_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clkin cycles from a stable input to q.
// Backpressure: none; level signal only.
// Ports: clkin/rstb clock and async active-low reset, d async input, q synchronized output.
module sync_2ff (
  input  logic clkin,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Range-checks ratio writes and hands them to the divider over a four-phase req/ack handshake.
// Latency: req rises 1 cycle after an accepted write; done/err pulses 1 cycle after the deciding event.
// Backpressure: none on cfg_wr; one pending write is held (last wins), cfg_busy reports it.
// Ports: clkin/rstb; cfg_wr/cfg_ratio write in; cfg_busy/cfg_done/cfg_err/err_code status out;
//        cur_ratio last acknowledged ratio; ratio/ratio_upd_req to divider, ratio_upd_ack from divider.
module clkdiv_ratio_ctrl
  import clkdiv_pkg::*;
#(
  parameter int RATIO_W     = RATIO_W_DFLT,
  parameter int RATIO_MIN   = 2,
  parameter int RATIO_MAX   = 1023,
  parameter int RESET_RATIO = 10,
  parameter int HOLD_CYC    = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clkin,
  input  logic               rstb,
  input  logic               cfg_wr,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic [1:0]         err_code,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic [RATIO_W-1:0] ratio,
  output logic               ratio_upd_req,
  input  logic               ratio_upd_ack
);

  localparam int                 TMR_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(ACK_TIMEOUT);
  localparam int                 HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  // Range limits are compared one bit wider so a limit at the top of the bus stays a real compare.
  localparam logic [RATIO_W:0]   MIN_X     = (RATIO_W + 1)'(RATIO_MIN);
  localparam logic [RATIO_W:0]   MAX_X     = (RATIO_W + 1)'(RATIO_MAX);
  localparam logic [RATIO_W-1:0] RST_R     = RATIO_W'(RESET_RATIO);

  state_e             state_q, state_d;
  err_e               err_q;
  logic               ack_s;
  logic [TMR_W-1:0]   timer_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               pend_v;
  logic [RATIO_W-1:0] pend_r;

  logic [RATIO_W:0]   cfg_ratio_x;
  logic               wr_ok, wr_bad;
  logic               idle_req_v, idle_noop;
  logic [RATIO_W-1:0] idle_req_r;
  logic               drop_done, abort_entry, launch;

  sync_2ff u_ack_sync (
    .clkin (clkin),
    .rstb  (rstb),
    .d     (ratio_upd_ack),
    .q     (ack_s)
  );

  assign cfg_ratio_x = {1'b0, cfg_ratio};
  assign wr_ok       = cfg_wr & (cfg_ratio_x >= MIN_X) & (cfg_ratio_x <= MAX_X);
  assign wr_bad      = cfg_wr & ~wr_ok;

  // In IDLE a fresh legal write supersedes the pending one (last wins).
  assign idle_req_v  = (state_q == IDLE) & (wr_ok | pend_v);
  assign idle_req_r  = wr_ok ? cfg_ratio : pend_r;
  assign idle_noop   = idle_req_v & (idle_req_r == cur_ratio);

  assign drop_done   = (state_q == DROP) & ~ack_s;
  assign abort_entry = (state_d == ABORT) & (state_q != ABORT);
  assign launch      = (state_q == IDLE) & (state_d == REQ);

  // State register
  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (idle_req_v && !idle_noop) state_d = REQ;
      REQ:   if (ack_s) state_d = HOLD;
             else if (timer_q == TMR_MAX) state_d = ABORT;
      HOLD:  if (hold_q == HOLD_LAST) state_d = DROP;
      DROP:  if (!ack_s) state_d = IDLE;
             else if (timer_q == TMR_MAX) state_d = ABORT;
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ratio_upd_req = (state_q == REQ) || (state_q == HOLD);
    cfg_busy      = (state_q != IDLE) || pend_v;
  end

  assign err_code = err_q;

  // Datapath: timers, ratio registers, pending slot and status pulses
  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      timer_q   <= '0;
      hold_q    <= '0;
      ratio     <= RST_R;
      cur_ratio <= RST_R;
      pend_v    <= 1'b0;
      pend_r    <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_q     <= NONE;
    end else begin
      // Per-phase timer restarts on every state change and only advances while waiting on ack_s.
      if (state_d != state_q)
        timer_q <= '0;
      else if (((state_q == REQ) || (state_q == DROP)) && (timer_q != TMR_MAX))
        timer_q <= timer_q + 1'b1;

      hold_q <= (state_q == HOLD) ? hold_q + 1'b1 : '0;

      // ratio only moves with req low: on launch out of IDLE, or restored after an abort.
      if (launch)
        ratio <= idle_req_r;
      else if (state_q == ABORT)
        ratio <= cur_ratio;

      if (drop_done)
        cur_ratio <= ratio;

      // Pending slot: consumed in IDLE, flushed by abort, overwritten by any legal write elsewhere.
      if (idle_req_v || (state_q == ABORT))
        pend_v <= 1'b0;
      if ((state_q != IDLE) && wr_ok) begin
        pend_v <= 1'b1;
        pend_r <= cfg_ratio;
      end

      cfg_done <= drop_done | idle_noop;
      cfg_err  <= wr_bad | abort_entry;

      if (abort_entry)
        err_q <= TIMEOUT;
      else if (wr_bad)
        err_q <= RANGE;
      else if (cfg_wr)
        err_q <= NONE;
    end
  end

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
module tb_clkdiv_ratio_ctrl;

  localparam int RW          = 10;
  localparam int RMIN        = 2;
  localparam int RMAX        = 1023;
  localparam int RRESET      = 10;
  localparam int HOLD_CYC    = 2;
  localparam int ACK_TIMEOUT = 255;

  logic          clkin = 1'b0;
  logic          rstb  = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [RW-1:0] cfg_ratio = '0;
  logic          cfg_busy, cfg_done, cfg_err;
  logic [1:0]    err_code;
  logic [RW-1:0] cur_ratio, ratio;
  logic          ratio_upd_req;
  logic          ratio_upd_ack;

  clkdiv_ratio_ctrl dut (
    .clkin         (clkin),
    .rstb          (rstb),
    .cfg_wr        (cfg_wr),
    .cfg_ratio     (cfg_ratio),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .err_code      (err_code),
    .cur_ratio     (cur_ratio),
    .ratio         (ratio),
    .ratio_upd_req (ratio_upd_req),
    .ratio_upd_ack (ratio_upd_ack)
  );

  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the divider should hold and what status the last write left.
  logic [RW-1:0] m_cur  = RRESET;
  logic [1:0]    m_code = 2'b00;

  // Divider stand-in state
  logic          ack_en = 1'b1;
  int            dly = 0;
  logic [RW-1:0] got_q[$];

  // Monitor state
  int   done_cnt = 0, err_cnt = 0;
  int   req_run = 0, hold_cnt = 0, last_run = 0, last_hold = 0;
  logic h1 = 1'b0, h2 = 1'b0, acks_m = 1'b0;
  logic prev_req = 1'b0, prev_acks = 1'b0, prev_rstb = 1'b0;
  logic [RW-1:0] prev_ratio = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    n_cmp++;
    assert ((got >= lo) && (got <= hi)) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  function automatic logic legal(input logic [RW-1:0] r);
    return (int'(r) >= RMIN) && (int'(r) <= RMAX);
  endfunction

  // Divider stand-in: mirrors req onto ack after a random 0..3 cycle delay and
  // records the ratio it sees on each rising ack as a committed value.
  initial begin
    ratio_upd_ack = 1'b0;
    forever begin
      @(posedge clkin);
      #2;
      if (!ack_en) ratio_upd_ack = 1'b0;
      else if (ratio_upd_ack != ratio_upd_req) begin
        if (dly == 0) begin
          ratio_upd_ack = ratio_upd_req;
          if (ratio_upd_req) got_q.push_back(ratio);
          dly = $urandom_range(0, 3);
        end else dly--;
      end
    end
  end

  // Monitor: pulse counting, req run lengths, hold length after synchronized ack, ratio stability.
  initial begin
    forever begin
      @(negedge clkin);
      acks_m = h2;
      h2 = h1;
      h1 = ratio_upd_ack;
      if (cfg_done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (ratio_upd_req) begin
        req_run++;
        if (acks_m) hold_cnt++;
      end else begin
        if (prev_req) begin
          last_run  = req_run;
          last_hold = hold_cnt;
        end
        req_run  = 0;
        hold_cnt = 0;
      end
      if (rstb && prev_rstb && ((prev_req && ratio_upd_req) || (prev_acks && acks_m)))
        chk("ratio_stable", 32'(ratio), 32'(prev_ratio));
      prev_req   = ratio_upd_req;
      prev_acks  = acks_m;
      prev_ratio = ratio;
      prev_rstb  = rstb;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_wr(input logic [RW-1:0] r);
    cfg_wr    = 1'b1;
    cfg_ratio = r;
    @(negedge clkin);
    cfg_wr    = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((cfg_busy || ratio_upd_req || ratio_upd_ack) && t < 3000) begin
      @(negedge clkin);
      t++;
    end
    chk("idle_reached", 32'(t < 3000), 32'd1);
  endtask

  // One transaction: a write from IDLE, optionally followed by extra writes while its handshake runs.
  task automatic run_step(input logic [RW-1:0] r1, input int n_ext,
                          input logic [RW-1:0] e0, input logic [RW-1:0] e1);
    logic [RW-1:0] q_exp[$];
    logic [RW-1:0] ex, pr;
    logic          pv;
    int            d0, er0, exp_d, exp_e;
    wait_idle();
    #1;
    got_q.delete();
    d0 = done_cnt; er0 = err_cnt; exp_d = 0; exp_e = 0; pv = 1'b0; pr = '0;
    @(negedge clkin);
    do_wr(r1);
    if (!legal(r1)) begin
      exp_e++; m_code = 2'b01;
    end else if (r1 == m_cur) begin
      exp_d++; m_code = 2'b00;
    end else begin
      chk("req_next_cycle", 32'(ratio_upd_req), 32'd1);
      q_exp.push_back(r1); m_cur = r1; exp_d++; m_code = 2'b00;
      for (int k = 0; k < n_ext; k++) begin
        repeat ($urandom_range(0, 1)) @(negedge clkin);
        ex = (k == 0) ? e0 : e1;
        do_wr(ex);
        if (!legal(ex)) begin
          exp_e++; m_code = 2'b01;
        end else begin
          pv = 1'b1; pr = ex; m_code = 2'b00;
        end
      end
      if (pv) begin
        exp_d++;
        if (pr != m_cur) begin
          q_exp.push_back(pr); m_cur = pr;
        end
      end
    end
    repeat (3) @(negedge clkin);
    wait_idle();
    repeat (3) @(negedge clkin);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 32'(exp_d));
    chk("err_pulses", 32'(err_cnt - er0), 32'(exp_e));
    chk("commit_count", 32'(got_q.size()), 32'(q_exp.size()));
    for (int k = 0; k < q_exp.size() && k < got_q.size(); k++)
      chk("commit_value", 32'(got_q[k]), 32'(q_exp[k]));
    chk("cur_ratio", 32'(cur_ratio), 32'(m_cur));
    chk("ratio_idle", 32'(ratio), 32'(m_cur));
    chk("err_code", 32'(err_code), 32'(m_code));
  endtask

  initial begin
    int            bad;
    int            t;
    int            er0, d0;
    int            v;
    logic [RW-1:0] r, ra, rb, rc;

    // 1: reset and 50 quiet cycles
    repeat (3) @(negedge clkin);
    chk("rst_req", 32'(ratio_upd_req), 32'd0);
    chk("rst_ratio", 32'(ratio), 32'(RRESET));
    rstb = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clkin);
      if (ratio != RW'(RRESET) || ratio_upd_req || cfg_busy || cfg_done || cfg_err) bad++;
    end
    chk("quiet_after_reset", 32'(bad), 32'd0);
    chk("rst_cur_ratio", 32'(cur_ratio), 32'(RRESET));
    chk("rst_err_code", 32'(err_code), 32'd0);

    // 2: single commit, plus req hold length after synchronized ack
    run_step(RW'(25), 0, '0, '0);
    chk_rng("hold_after_ack_s", last_hold, HOLD_CYC, HOLD_CYC + 1);

    // 3: out-of-range writes (1024 wraps to 0 on a 10-bit bus, still out of range)
    run_step(RW'(1), 0, '0, '0);
    v = 1024;
    run_step(v[RW-1:0], 0, '0, '0);

    // no-op write equal to the current ratio
    run_step(RW'(25), 0, '0, '0);

    // 4: writes during a handshake, last one wins
    run_step(RW'(30), 2, RW'(31), RW'(32));

    // randomized transactions
    for (int s = 0; s < 24; s++) begin
      case ($urandom_range(0, 5))
        0:       ra = RW'($urandom_range(0, 1));
        1:       ra = m_cur;
        default: ra = RW'($urandom_range(2, 1023));
      endcase
      rb = ($urandom_range(0, 3) == 0) ? RW'($urandom_range(0, 1)) : RW'($urandom_range(2, 1023));
      rc = ($urandom_range(0, 3) == 0) ? RW'($urandom_range(0, 1)) : RW'($urandom_range(2, 1023));
      run_step(ra, $urandom_range(0, 2), rb, rc);
    end

    // 5: ack never comes -> timeout abort restores ratio
    wait_idle();
    #1;
    ack_en = 1'b0;
    er0 = err_cnt; d0 = done_cnt;
    got_q.delete();
    r = (m_cur == RW'(20)) ? RW'(21) : RW'(20);
    @(negedge clkin);
    do_wr(r);
    t = 0;
    #1;
    while (err_cnt == er0 && t < 400) begin
      @(negedge clkin);
      #1;
      t++;
    end
    chk("abort_err_pulse", 32'(err_cnt - er0), 32'd1);
    chk("abort_err_code", 32'(err_code), 32'd2);
    chk_rng("abort_req_len", last_run, ACK_TIMEOUT, ACK_TIMEOUT + 2);
    @(negedge clkin);
    #1;
    chk("abort_ratio_back", 32'(ratio), 32'(m_cur));
    chk("abort_req_low", 32'(ratio_upd_req), 32'd0);
    repeat (3) @(negedge clkin);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_not_busy", 32'(cfg_busy), 32'd0);
    chk("abort_cur_ratio", 32'(cur_ratio), 32'(m_cur));
    ack_en = 1'b1;
    m_code = 2'b10;

    // 6: reset asserted in the middle of HOLD
    wait_idle();
    r = (m_cur == RW'(40)) ? RW'(41) : RW'(40);
    @(negedge clkin);
    do_wr(r);
    t = 0;
    #1;
    while (!(ratio_upd_req && acks_m) && t < 100) begin
      @(negedge clkin);
      #1;
      t++;
    end
    chk("reached_hold", 32'(t < 100), 32'd1);
    @(negedge clkin);
    #2;
    rstb = 1'b0;
    #1;
    chk("async_rst_req", 32'(ratio_upd_req), 32'd0);
    chk("async_rst_ratio", 32'(ratio), 32'(RRESET));
    chk("async_rst_cur", 32'(cur_ratio), 32'(RRESET));
    chk("async_rst_busy", 32'(cfg_busy), 32'd0);
    chk("async_rst_pulses", 32'({cfg_done, cfg_err}), 32'd0);
    chk("async_rst_err_code", 32'(err_code), 32'd0);
    repeat (2) @(negedge clkin);
    rstb = 1'b1;
    m_cur = RW'(RRESET);
    m_code = 2'b00;

    // recovery after reset
    run_step(RW'(77), 1, RW'(78), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
